logicnet_lut_loader: RTL

// - Runtime-programmable LogicNets LUT neuron: the writer side of a fixed truth-table neuron ROM.
// - Receives truth-table contents as a valid/ready word stream and stores them in a 2^IN_BITS x OUT_BITS table.
// - Serves registered lookups from that table.
// - Sits beside the synthesized layer neurons, so a table can be retrained and swapped without resynthesis.

---
 rtl/logicnet_pkg.sv | 31 +++
 rtl/lut_table_ram.sv | 60 ++++++
 rtl/logicnet_lut_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/logicnet_pkg.sv
// Shared types and sizing helpers for the LogicNets LUT loader.
//   lut_ld_state_t : loader FSM states
//   depth()        : table depth for a given address width
//   nwords()       : config words needed to fill one table
//   cnt_width()    : word counter width (at least 1 bit)
package logicnet_pkg;

    localparam int unsigned DEF_IN_BITS  = 8;
    localparam int unsigned DEF_OUT_BITS = 1;
    localparam int unsigned DEF_CFG_W    = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } lut_ld_state_t;

    function automatic int unsigned depth(input int unsigned in_bits);
        return 32'(1) << in_bits;
    endfunction

    function automatic int unsigned nwords(input int unsigned in_bits,
                                           input int unsigned out_bits,
                                           input int unsigned cfg_w);
        return (depth(in_bits) * out_bits) / cfg_w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// DEPTH x OUT_BITS flop table with a word-wide packed write port and a
// registered read port. Flops are used so reset can clear the whole table.
//   clk, rst : clock, asynchronous active-high reset
//   we       : write one config word this cycle
//   waddr    : config word index
//   wdata    : config word, entry j of the word in bits [j*OUT_BITS +: OUT_BITS]
//   re       : lookup this cycle
//   raddr    : lookup address
//   rdata    : registered lookup result, holds when re is low
module lut_table_ram
    import logicnet_pkg::*;
#(
    parameter  int unsigned IN_BITS  = DEF_IN_BITS,
    parameter  int unsigned OUT_BITS = DEF_OUT_BITS,
    parameter  int unsigned CFG_W    = DEF_CFG_W,
    localparam int unsigned CNT_W    = cnt_width(nwords(IN_BITS, OUT_BITS, CFG_W))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [CNT_W-1:0]    waddr,
    input  logic [CFG_W-1:0]    wdata,
    input  logic                re,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int unsigned DEPTH  = depth(IN_BITS);
    localparam int unsigned NWORDS = nwords(IN_BITS, OUT_BITS, CFG_W);
    localparam int unsigned EPW    = CFG_W / OUT_BITS;

    logic [OUT_BITS-1:0] mem_q [DEPTH];

    // Table storage: a word scatters EPW consecutive entries starting at waddr*EPW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < int'(NWORDS); k++) begin
                if (waddr == CNT_W'(k)) begin
                    for (int j = 0; j < int'(EPW); j++) begin
                        mem_q[k*int'(EPW) + j] <= wdata[j*int'(OUT_BITS) +: OUT_BITS];
                    end
                end
            end
        end
    end

    // Registered read; same-edge writes are not visible until the next lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/logicnet_lut_loader.sv
// Runtime-programmable LogicNets LUT neuron: loads a truth table from a
// valid/ready config stream and serves registered lookups from it.
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_start  : pulse, begin or restart a table load
//   cfg_valid  : config word valid
//   cfg_data   : config word
//   cfg_ready  : loader accepts a word this cycle
//   cfg_done   : table holds a complete load (sticky)
//   in_valid   : lookup request valid
//   in_data    : lookup address
//   in_ready   : lookup accepted this cycle
//   out_valid  : lookup result valid (one cycle after acceptance)
//   out_data   : table entry for the accepted address
module logicnet_lut_loader
    import logicnet_pkg::*;
#(
    parameter int unsigned IN_BITS  = DEF_IN_BITS,
    parameter int unsigned OUT_BITS = DEF_OUT_BITS,
    parameter int unsigned CFG_W    = DEF_CFG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_ready,
    output logic                cfg_done,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int unsigned DEPTH  = depth(IN_BITS);
    localparam int unsigned NWORDS = nwords(IN_BITS, OUT_BITS, CFG_W);
    localparam int unsigned CNT_W  = cnt_width(NWORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    if (((DEPTH * OUT_BITS) % CFG_W) != 0) begin : g_bad_cfg
        $error("logicnet_lut_loader: DEPTH*OUT_BITS must be a multiple of CFG_W");
    end

    lut_ld_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_d;
    logic             we_c;
    logic             take_c;
    logic             lookup_c;

    // cfg_ready mirrors state==LOAD, so a word is taken only while loading.
    assign take_c   = cfg_ready && cfg_valid;
    assign in_ready = (state_q != LOAD) && !cfg_start;
    assign lookup_c = in_valid && in_ready;

    // Next-state: cfg_start wins over a word arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = cfg_done;
        we_c    = 1'b0;
        if (cfg_start) begin
            state_d = LOAD;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (take_c) begin
            we_c = 1'b1;
            if (cnt_q == LAST_WORD) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Loader state, word counter and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cfg_done  <= 1'b0;
            cfg_ready <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_done  <= done_d;
            cfg_ready <= (state_d == LOAD);
            out_valid <= lookup_c;
        end
    end

    lut_table_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_W    (CFG_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (we_c),
        .waddr (cnt_q),
        .wdata (cfg_data),
        .re    (lookup_c),
        .raddr (in_data),
        .rdata (out_data)
    );

endmodule
